// File: rtl/dot_product_engine_if.sv
// Operand/result bundle for the dot-product engine: k/x request side plus y/ovf response side.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface dot_product_engine_if #(
    parameter int BITWIDTH = 32,
    parameter int MATSIZE  = 16
);
    localparam int ACCW = 2*BITWIDTH + $clog2(MATSIZE) + 1;

    logic                              in_valid;
    logic                              in_ready;
    logic [MATSIZE-1:0][BITWIDTH-1:0]  k;
    logic [MATSIZE-1:0][BITWIDTH-1:0]  x;
    logic                              out_valid;
    logic                              out_ready;
    logic signed [ACCW-1:0]            y;
    logic                              ovf;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, k, x, out_ready,
        input  in_ready, out_valid, y, ovf
    );

    // The engine itself.
    modport slave (
        input  in_valid, k, x, out_ready,
        output in_ready, out_valid, y, ovf
    );
endinterface

// File: rtl/dot_product_engine.sv
// Signed dot product y = sum(k[i]*x[i]) with a LANES-wide adder tree reused over NGRP cycles.
// Latency: accept edge E0, out_valid rises after edge E0+NGRP+1; one transaction in flight.
// Backpressure: in_ready low from accept until the result is taken; result holds until out_ready.
module dot_product_engine #(
    parameter int BITWIDTH = 32,
    parameter int MATSIZE  = 16,
    parameter int LANES    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    dot_product_engine_if.slave  bus
);
    localparam int NGRP = (MATSIZE + LANES - 1) / LANES;
    localparam int ACCW = 2*BITWIDTH + $clog2(MATSIZE) + 1;
    localparam int PW   = 2*BITWIDTH;
    localparam int XW   = ACCW - PW;
    localparam int PADN = NGRP * LANES;
    localparam int IW   = (PADN > 1) ? $clog2(PADN) : 1;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // FSM state and registered outputs
    state_t                           state_q;
    logic                             in_ready_q;
    logic                             out_valid_q;
    logic [ACCW-1:0]                  y_q;
    logic                             ovf_q;

    // Datapath state
    logic [MATSIZE-1:0][BITWIDTH-1:0] k_q, k_d;
    logic [MATSIZE-1:0][BITWIDTH-1:0] x_q, x_d;
    logic [MATSIZE-1:0][PW-1:0]       prod_q, prod_d;
    logic [ACCW-1:0]                  acc_q, acc_d;
    logic [GW-1:0]                    grp_q, grp_d;

    // Reduction helpers
    logic [PW-1:0]                    prod_pad [2**IW];
    logic [IW-1:0]                    lane_idx;
    logic [ACCW-1:0]                  lane_sum;
    logic [ACCW-1:0]                  acc_sum;
    logic                             sum_ovf;
    logic                             last_grp;

    assign last_grp = (grp_q == GW'(NGRP - 1));

    // Product array padded with zeros so the last, partially filled group adds nothing extra.
    always_comb begin
        for (int i = 0; i < 2**IW; i++) begin
            prod_pad[i] = '0;
        end
        for (int i = 0; i < MATSIZE; i++) begin
            prod_pad[i] = prod_q[i];
        end
    end

    // Sign-extend the current group's LANES products to ACCW and add them to the accumulator.
    always_comb begin
        lane_sum = '0;
        lane_idx = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_idx = IW'(grp_q) * IW'(LANES) + IW'(l);
            lane_sum = lane_sum + {{XW{prod_pad[lane_idx][PW-1]}}, prod_pad[lane_idx]};
        end
        acc_sum = acc_q + lane_sum;
        // Fits in signed BITWIDTH only if bits [ACCW-1:BITWIDTH-1] are all copies of the sign.
        sum_ovf = !((&acc_sum[ACCW-1:BITWIDTH-1]) || !(|acc_sum[ACCW-1:BITWIDTH-1]));
    end

    // Next-state values for operand latches, products, accumulator and group counter.
    always_comb begin
        k_d    = k_q;
        x_d    = x_q;
        prod_d = prod_q;
        acc_d  = acc_q;
        grp_d  = grp_q;
        if (clear) begin
            acc_d = '0;
            grp_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        k_d = bus.k;
                        x_d = bus.x;
                    end
                end
                MUL: begin
                    for (int i = 0; i < MATSIZE; i++) begin
                        prod_d[i] = $signed({{BITWIDTH{k_q[i][BITWIDTH-1]}}, k_q[i]})
                                  * $signed({{BITWIDTH{x_q[i][BITWIDTH-1]}}, x_q[i]});
                    end
                    acc_d = '0;
                    grp_d = '0;
                end
                ACC: begin
                    acc_d = acc_sum;
                    grp_d = grp_q + GW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q    <= '0;
            x_q    <= '0;
            prod_q <= '0;
            acc_q  <= '0;
            grp_q  <= '0;
        end else begin
            k_q    <= k_d;
            x_q    <= x_d;
            prod_q <= prod_d;
            acc_q  <= acc_d;
            grp_q  <= grp_d;
        end
    end

    // Control FSM; the result is captured on the last accumulate so y/ovf stay frozen in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
        end else if (clear) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q    <= MUL;
                        in_ready_q <= 1'b0;
                    end
                end
                MUL: begin
                    state_q <= ACC;
                end
                ACC: begin
                    if (last_grp) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        y_q         <= acc_sum;
                        ovf_q       <= sum_ovf;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.ovf       = ovf_q;
endmodule
